gpr_wb_queue: RTL
=================

GPR_WB_QUEUE -- requirements
Module: gpr_wb_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named as follows.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low.
REQ-002 The write-request port SHALL be:
- req_valid  in  1  producer has a write request.
- req_ready  out  1  queue can accept a request.
- req_addr  in  5  target GPR index.
- req_data  in  32  value to write.
REQ-003 The register-file write port SHALL be registered outputs that drive the GPR write port directly:
- Write_Reg  out  1  write strobe.
- W_Addr  out  5  write address.
- W_Data  out  32  write data.
REQ-004 The remaining ports SHALL be:
- stall  in  1  register-file write port unavailable this cycle.
- count  out  3  occupied entries, 0..4.
- empty  out  1  count==0.
- full  out  1  count==4.

Function
REQ-005 The queue SHALL be a 4-entry FIFO with 2-bit read and write pointers that wrap 3->0.
REQ-006 A handshake SHALL occur when req_valid && req_ready at a rising edge.
REQ-007 req_ready SHALL equal !full and SHALL NOT depend on req_valid or on a same-cycle pop; a full queue never accepts a request, even while popping.
REQ-008 A handshake with req_addr==0 SHALL consume the request without enqueuing it; count is unchanged.
REQ-009 At each edge where !empty && !stall, the head entry SHALL be popped and loaded into W_Addr/W_Data with Write_Reg=1.
REQ-010 At each edge without a pop, Write_Reg SHALL be 0 and W_Addr/W_Data SHALL hold their previous values.
REQ-011 Latency: a request accepted at edge N into an empty queue with stall low SHALL be popped at edge N+1, with Write_Reg high in the cycle after N+1.
REQ-012 Order SHALL be strictly FIFO; one pop per cycle maximum.
REQ-013 A simultaneous push and pop SHALL leave count unchanged and both pointers advanced.
REQ-014 stall asserted SHALL freeze pops only; pushes continue until full.
REQ-015 count, empty and full SHALL be derived from registered state only.

Reset
REQ-016 While rst==0 at an edge: pointers=0, count=0, Write_Reg=0, W_Addr=0, W_Data=0.
REQ-017 A reset mid-operation SHALL discard all pending entries; no write strobe is issued for them.
REQ-018 req_ready SHALL be 0 while rst==0 and 1 in the first cycle after release.

Configuration
REQ-019 Macro GPR_WB_BYPASS_EN, when defined, SHALL add the ports q_addr (in, 5), q_hit (out, 1) and q_data (out, 32).
REQ-020 With GPR_WB_BYPASS_EN defined, q_hit SHALL be combinational: 1 when q_addr!=0 and q_addr matches any valid queue entry or the output register while Write_Reg==1.
REQ-021 With GPR_WB_BYPASS_EN defined, q_data SHALL be taken from the youngest match, with queue entries younger than the output register; q_data=0 when q_hit==0.
REQ-022 Without GPR_WB_BYPASS_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-023 After reset release, one push (addr 5, data 0x1234_5678) with stall low -> Write_Reg=1, W_Addr=5, W_Data=0x12345678 exactly two cycles after acceptance; count returns to 0.
REQ-024 With stall high, push 5 requests -> first 4 accepted, req_ready=0 on the 5th, full=1, count=4; release stall -> 4 strobes on consecutive cycles in push order.
REQ-025 Push addr 0 data 0xDEAD_BEEF -> handshake completes, count stays 0, no Write_Reg pulse.
REQ-026 Queue at count 2, reset asserted for 1 cycle -> count=0, Write_Reg=0, no strobes for the discarded entries after release.
REQ-027 With GPR_WB_BYPASS_EN and stall high, push (7, 0x11) then (7, 0x22) and set q_addr=7 -> q_hit=1, q_data=0x22; set q_addr=0 -> q_hit=0.
REQ-028 Continuous push and pop at count 2 for 10 cycles -> count stays 2, pointers wrap cleanly, data order is preserved.

Source files
------------

// File: rtl/gpr_wb_queue.sv
// 4-entry write-back queue feeding the GPR write port; drops writes to x0.
// Optional GPR_WB_BYPASS_EN adds a read-side lookup (q_addr/q_hit/q_data).
module gpr_wb_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_data,
  output logic        Write_Reg,
  output logic [4:0]  W_Addr,
  output logic [31:0] W_Data,
  input  logic        stall,
  output logic [2:0]  count,
  output logic        empty,
  output logic        full
`ifdef GPR_WB_BYPASS_EN
  ,
  input  logic [4:0]  q_addr,
  output logic        q_hit,
  output logic [31:0] q_data
`endif
);

  logic [4:0]  addr_q [4];
  logic [31:0] data_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        wreg_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        hs, push, pop;

  assign empty     = (count_q == 3'd0);
  assign full      = (count_q == 3'd4);
  assign count     = count_q;
  assign req_ready = rst & ~full;
  assign hs        = req_valid & req_ready;
  // A handshake to x0 is consumed but never stored.
  assign push      = hs & (req_addr != 5'd0);
  assign pop       = ~empty & ~stall;

  assign Write_Reg = wreg_q;
  assign W_Addr    = waddr_q;
  assign W_Data    = wdata_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= req_addr;
      data_q[wr_ptr_q] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      wreg_q   <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
        waddr_q  <= addr_q[rd_ptr_q];
        wdata_q  <= data_q[rd_ptr_q];
      end
      wreg_q  <= pop;
      count_q <= count_d;
    end
  end

`ifdef GPR_WB_BYPASS_EN
  logic [1:0] idx;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = 32'd0;
    idx    = 2'd0;
    if (q_addr != 5'd0) begin
      if (wreg_q && (waddr_q == q_addr)) begin
        q_hit  = 1'b1;
        q_data = wdata_q;
      end
      for (int k = 0; k < 4; k++) begin
        idx = rd_ptr_q + k[1:0];
        if ((3'(k) < count_q) && (addr_q[idx] == q_addr)) begin
          q_hit  = 1'b1;
          q_data = data_q[idx];
        end
      end
    end
  end
`endif

endmodule
